key_conditioner: RTL and testbench

- Conditions raw board push-buttons before they reach the game core's left/right inputs.
- Per key, in order: 2-FF synchronizer, polarity normalization, counter-based debouncer, press/release edge pulses.
- Optional auto-repeat pulse generator per key.
- Runs in the board clock domain and drives the game wrapper's `keys` bus with a clean debounced level.

---
 rtl/key_conditioner.sv | 141 ++++++++++++++
 tb/tb_key_conditioner.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// key_conditioner
//
// Conditions raw board push-buttons for the game core. Each key passes through
// a 2-FF synchronizer, polarity normalization, a counter-based debouncer and
// registered press/release edge detection. An optional auto-repeat pulse
// generator is compiled in when the macro KEY_AUTOREPEAT_EN is defined.
// Without it, keys_repeat is tied to 0.
//
// Ports:
//   clk          board clock
//   reset        asynchronous, active-high reset
//   keys_in      raw asynchronous button inputs
//   keys_level   debounced level, 1 = pressed
//   keys_press   one-cycle pulse in the first cycle keys_level reads 1
//   keys_release one-cycle pulse in the first cycle keys_level reads 0 after 1
//   keys_repeat  auto-repeat pulses while held (0 when the feature is absent)

module key_conditioner #(
  parameter int unsigned N_KEYS     = 4,
  parameter int unsigned DEB_CYCLES = 500000,
  parameter int unsigned ACTIVE_LOW = 0,
  parameter int unsigned REP_DELAY  = 25000000,
  parameter int unsigned REP_PERIOD = 5000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] keys_in,
  output logic [N_KEYS-1:0] keys_level,
  output logic [N_KEYS-1:0] keys_press,
  output logic [N_KEYS-1:0] keys_release,
  output logic [N_KEYS-1:0] keys_repeat
);

  if (DEB_CYCLES < 1 || REP_DELAY < 1 || REP_PERIOD < 1) begin : g_param_check
    $error("key_conditioner: DEB_CYCLES, REP_DELAY and REP_PERIOD must be >= 1");
  end

  localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  // Raw value of a released key; also the synchronizer reset value.
  localparam logic [N_KEYS-1:0] IDLE_RAW = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [N_KEYS-1:0] sync1;
  logic [N_KEYS-1:0] sync2;
  logic [N_KEYS-1:0] samp;
  logic [N_KEYS-1:0] level_next;
  logic [DEB_W-1:0]  cnt      [N_KEYS];
  logic [DEB_W-1:0]  cnt_next [N_KEYS];

  // Normalized sample: 1 = pressed regardless of board polarity.
  assign samp = sync2 ^ IDLE_RAW;

  // Debouncer: count consecutive samples that disagree with the accepted
  // level; any agreeing sample restarts the count.
  always_comb begin
    level_next = keys_level;
    for (int i = 0; i < N_KEYS; i++) begin
      cnt_next[i] = cnt[i];
      if (samp[i] == keys_level[i]) begin
        cnt_next[i] = '0;
      end else if (cnt[i] == DEB_LAST) begin
        level_next[i] = samp[i];
        cnt_next[i]   = '0;
      end else begin
        cnt_next[i] = cnt[i] + DEB_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1        <= IDLE_RAW;
      sync2        <= IDLE_RAW;
      keys_level   <= '0;
      keys_press   <= '0;
      keys_release <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1        <= keys_in;
      sync2        <= sync1;
      keys_level   <= level_next;
      // Registered alongside the level so each pulse lines up with the first
      // cycle of the new level.
      keys_press   <= level_next & ~keys_level;
      keys_release <= ~level_next & keys_level;
      for (int i = 0; i < N_KEYS; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int unsigned REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REP_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REP_PERIOD - 1);

  logic [REP_W-1:0]  rep_cnt [N_KEYS];
  // Set until the first repeat of a hold has been issued.
  logic [N_KEYS-1:0] rep_first;

  // rep_cnt counts cycles since the press or the previous repeat pulse. It is
  // driven from level_next so a falling level suppresses any pulse landing in
  // the release cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      keys_repeat <= '0;
      rep_first   <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        rep_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_KEYS; i++) begin
        if (level_next[i] && !keys_level[i]) begin
          rep_cnt[i]     <= '0;
          rep_first[i]   <= 1'b1;
          keys_repeat[i] <= 1'b0;
        end else if (level_next[i]) begin
          if (rep_cnt[i] == (rep_first[i] ? DELAY_LAST : PERIOD_LAST)) begin
            rep_cnt[i]     <= '0;
            rep_first[i]   <= 1'b0;
            keys_repeat[i] <= 1'b1;
          end else begin
            rep_cnt[i]     <= rep_cnt[i] + REP_W'(1);
            keys_repeat[i] <= 1'b0;
          end
        end else begin
          rep_cnt[i]     <= '0;
          rep_first[i]   <= 1'b0;
          keys_repeat[i] <= 1'b0;
        end
      end
    end
  end
`else
  assign keys_repeat = '0;
`endif

endmodule

// File: tb/tb_key_conditioner.sv
module tb_key_conditioner;

  localparam int NK  = 4;
  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;

`ifdef KEY_AUTOREPEAT_EN
  localparam logic [3:0] REP_K0 = 4'b0001;
`else
  localparam logic [3:0] REP_K0 = 4'b0000;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] keys_in = 4'b0000;
  logic [3:0] keys_level;
  logic [3:0] keys_press;
  logic [3:0] keys_release;
  logic [3:0] keys_repeat;

  key_conditioner #(
    .N_KEYS     (NK),
    .DEB_CYCLES (DEB),
    .ACTIVE_LOW (0),
    .REP_DELAY  (RD),
    .REP_PERIOD (RP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .keys_in      (keys_in),
    .keys_level   (keys_level),
    .keys_press   (keys_press),
    .keys_release (keys_release),
    .keys_repeat  (keys_repeat)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the debouncer sees the raw value from two edges earlier;
  // a key's level flips once its sample has held the opposite value for DEB
  // consecutive edges. Repeats fall at press + RD + m*RP while held.
  logic [3:0] hist[$];
  int         edge_n;
  logic [3:0] prev_samp;
  logic [3:0] mlevel;
  logic [3:0] e_press;
  logic [3:0] e_rel;
  logic [3:0] e_rep;
  int         run_start [NK];
  int         press_edge [NK];

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic model_clear();
    hist.delete();
    edge_n    = 0;
    prev_samp = '0;
    mlevel    = '0;
    e_press   = '0;
    e_rel     = '0;
    e_rep     = '0;
    for (int i = 0; i < NK; i++) begin
      run_start[i]  = 0;
      press_edge[i] = -1000;
    end
  endtask

  task automatic model_step();
    logic [3:0] s;
    edge_n++;
    hist.push_back(keys_in);
    s = (edge_n >= 3) ? hist[edge_n-3] : 4'b0000;
    e_press = '0;
    e_rel   = '0;
    e_rep   = '0;
    for (int i = 0; i < NK; i++) begin
      if (edge_n == 1 || s[i] != prev_samp[i]) run_start[i] = edge_n;
      prev_samp[i] = s[i];
      if (s[i] != mlevel[i] && (edge_n - run_start[i] + 1) >= DEB) begin
        mlevel[i] = s[i];
        if (s[i]) begin
          e_press[i]    = 1'b1;
          press_edge[i] = edge_n;
        end else begin
          e_rel[i] = 1'b1;
        end
      end
`ifdef KEY_AUTOREPEAT_EN
      if (mlevel[i] && (edge_n - press_edge[i]) >= RD &&
          ((edge_n - press_edge[i] - RD) % RP) == 0) begin
        e_rep[i] = 1'b1;
      end
`endif
    end
  endtask

  // Called at a negedge; drives inputs, takes one edge, checks, returns at
  // the following negedge.
  task automatic cyc(input logic [3:0] v);
    keys_in = v;
    @(posedge clk);
    model_step();
    #1;
    check("level", keys_level, mlevel);
    check("press", keys_press, e_press);
    check("release", keys_release, e_rel);
    check("repeat", keys_repeat, e_rep);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] r;
    int len;

    // Reset state
    #1 reset = 1'b1;
    #2;
    check("rst_level", keys_level, 4'b0000);
    check("rst_press", keys_press, 4'b0000);
    check("rst_release", keys_release, 4'b0000);
    check("rst_repeat", keys_repeat, 4'b0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear();

    // Clean press on key 0 and long hold (auto-repeat)
    repeat (3) cyc(4'b0000);
    for (int j = 1; j <= 31; j++) begin
      cyc(4'b0001);
      if (j == 5) check("s1_level_early", keys_level, 4'b0000);
      if (j == 6) begin
        check("s1_level", keys_level, 4'b0001);
        check("s1_press", keys_press, 4'b0001);
      end
      if (j == 7) check("s1_press_end", keys_press, 4'b0000);
      if (j == 15) check("s6_rep_early", keys_repeat, 4'b0000);
      if (j == 16) check("s6_rep_first", keys_repeat, REP_K0);
      if (j == 19) check("s6_rep_second", keys_repeat, REP_K0);
    end

    // Release of key 0
    for (int j = 1; j <= 10; j++) begin
      cyc(4'b0000);
      if (j == 5) begin
        check("s3_release_early", keys_release, 4'b0000);
        check("s3_level_held", keys_level, 4'b0001);
      end
      if (j == 6) begin
        check("s3_release", keys_release, 4'b0001);
        check("s3_level_low", keys_level, 4'b0000);
        check("s3_no_rep", keys_repeat, 4'b0000);
      end
      if (j == 7) check("s3_release_end", keys_release, 4'b0000);
    end

    // Glitch rejection on key 1
    repeat (3) cyc(4'b0010);
    repeat (8) cyc(4'b0000);
    check("s2_glitch_level", keys_level, 4'b0000);
    // One-cycle dip inside a 10-cycle high
    repeat (3) cyc(4'b0010);
    cyc(4'b0000);
    for (int j = 1; j <= 6; j++) begin
      cyc(4'b0010);
      if (j == 5) check("s2_dip_early", keys_level, 4'b0000);
      if (j == 6) check("s2_dip_press", keys_press, 4'b0010);
    end
    repeat (10) cyc(4'b0000);

    // Simultaneous keys
    for (int j = 1; j <= 8; j++) begin
      cyc(4'b1010);
      if (j == 6) check("s4_press", keys_press, 4'b1010);
    end
    check("s4_level", keys_level, 4'b1010);
    repeat (10) cyc(4'b0000);

    // Reset with key 2 pressed and key 3 mid-debounce
    repeat (8) cyc(4'b0100);
    check("s5_k2_level", keys_level, 4'b0100);
    repeat (4) cyc(4'b1100);
    reset = 1'b1;
    #1;
    check("s5_rst_level", keys_level, 4'b0000);
    check("s5_rst_press", keys_press, 4'b0000);
    check("s5_rst_release", keys_release, 4'b0000);
    check("s5_rst_repeat", keys_repeat, 4'b0000);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    for (int j = 1; j <= 8; j++) begin
      cyc(4'b1100);
      if (j == 5) check("s5_repress_early", keys_level, 4'b0000);
      if (j == 6) check("s5_repress", keys_press, 4'b1100);
    end
    repeat (10) cyc(4'b0000);

    // Randomized segments against the model
    for (int seg = 0; seg < 90; seg++) begin
      r = $urandom;
      len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(20, 35))
                                        : int'($urandom_range(1, 7));
      for (int j = 0; j < len; j++) cyc(r[3:0]);
    end
    repeat (12) cyc(4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
